// File: rtl/timer_seq_pkg.sv
// Shared constants for the timer sequencing arbiter: timer register map,
// control bits, command words, FSM state codes and load computation.
package timer_seq_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [15:0] WORD_STOP  = 16'h0008;
  localparam logic [15:0] WORD_START = 16'h0005;
  localparam logic [15:0] WORD_CLEAR = 16'h0000;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_W_STOP = 4'd1;
  localparam logic [3:0] S_W_PERL = 4'd2;
  localparam logic [3:0] S_W_PERH = 4'd3;
  localparam logic [3:0] S_W_STAT = 4'd4;
  localparam logic [3:0] S_W_CTRL = 4'd5;
  localparam logic [3:0] S_WAIT   = 4'd6;
  localparam logic [3:0] S_ACK    = 4'd7;
  localparam logic [3:0] S_REL    = 4'd8;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } tmr_wr_t;

  // Timer counts load..0, so a timeout takes load+1 cycles.
  function automatic logic [31:0] calc_load(input logic [31:0] period);
    return (period < 32'd2) ? 32'd1 : period - 32'd1;
  endfunction

endpackage

// File: rtl/timer_seq_if.sv
// Interval-timer slave write port plus its level interrupt.
// Master side is the sequencer, slave side is the timer.
interface timer_seq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output irq
  );
endinterface

// File: rtl/timer_seq_rr_arb.sv
// Round-robin selector: the first requester strictly after the last
// owner wins; returns one-hot grant, its index and a valid flag.
module timer_seq_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  int slot;

  // Scan farthest-first so the nearest requester is written last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    slot = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      slot = (int'(last) + k) % NUM_REQ;
      if (req[IDX_W'(slot)]) begin
        gnt = '0;
        gnt[IDX_W'(slot)] = 1'b1;
        idx = IDX_W'(slot);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_seq_arbiter.sv
// Arbitrates requesters onto one interval timer and sequences its writes.
// Define TIMER_SEQ_ABORT_EN to let a one-shot owner abort by dropping req.
module timer_seq_arbiter
  import timer_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_period,
  input  logic [NUM_REQ-1:0]    req_continuous,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [IDX_W-1:0]      owner,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic                  tmr_irq
);

  logic [3:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [31:0]        load_q, load_d;
  logic               cont_q, cont_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  logic               own_req;
  logic               quit;
  logic               wr_en;
  tmr_wr_t            wr;

  timer_seq_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .vld  (arb_vld)
  );

  assign own_req = req[owner_q];

`ifdef TIMER_SEQ_ABORT_EN
  assign quit = !own_req;
`else
  assign quit = !own_req && cont_q;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    load_d  = load_q;
    cont_d  = cont_q;
    case (state_q)
      S_IDLE: begin
        if (arb_vld) begin
          grant_d = arb_gnt;
          owner_d = arb_idx;
          last_d  = arb_idx;
          load_d  = calc_load(req_period[int'(arb_idx)*32 +: 32]);
          cont_d  = req_continuous[arb_idx];
          state_d = S_W_STOP;
        end
      end
      S_W_STOP: state_d = S_W_PERL;
      S_W_PERL: state_d = S_W_PERH;
      S_W_PERH: state_d = S_W_STAT;
      S_W_STAT: state_d = S_W_CTRL;
      S_W_CTRL: state_d = S_WAIT;
      S_WAIT: begin
        if (tmr_irq)   state_d = S_ACK;
        else if (quit) state_d = S_REL;
      end
      S_ACK: state_d = (cont_q && own_req) ? S_WAIT : S_REL;
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    wr_en = 1'b1;
    wr    = '{addr: ADDR_STATUS, data: WORD_CLEAR};
    case (state_q)
      S_W_STOP: wr = '{addr: ADDR_CONTROL, data: WORD_STOP};
      S_W_PERL: wr = '{addr: ADDR_PERIODL, data: load_q[15:0]};
      S_W_PERH: wr = '{addr: ADDR_PERIODH, data: load_q[31:16]};
      S_W_STAT: wr = '{addr: ADDR_STATUS, data: WORD_CLEAR};
      S_W_CTRL: wr = '{addr: ADDR_CONTROL,
                       data: WORD_START | (16'(cont_q) << CTRL_CONT)};
      S_ACK:    wr = '{addr: ADDR_STATUS, data: WORD_CLEAR};
      S_REL:    wr = '{addr: ADDR_CONTROL, data: WORD_STOP};
      default:  wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      load_q  <= '0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      load_q  <= load_d;
      cont_q  <= cont_d;
    end
  end

  assign grant          = grant_q;
  assign owner          = owner_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_ACK) ? grant_q : '0;
  assign tmr_chipselect = wr_en;
  assign tmr_write_n    = !wr_en;
  assign tmr_address    = wr_en ? wr.addr : 3'd0;
  assign tmr_writedata  = wr_en ? wr.data : 16'd0;

endmodule

// File: tb/tb_timer_seq_arbiter.sv
// Self-checking bench for timer_seq_arbiter with a behavioural timer
// slave; honours TIMER_SEQ_ABORT_EN when defined.
module tb_timer_seq_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef TIMER_SEQ_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, req_continuous, grant, done;
  logic [N*32-1:0] req_period;
  logic            busy;
  logic [IW-1:0]   owner;
  int              errors = 0;
  int              checks = 0;
  int              last_owner;

  timer_seq_if bus ();

  always #5 clk = ~clk;

  timer_seq_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_period     (req_period),
    .req_continuous (req_continuous),
    .grant          (grant),
    .done           (done),
    .busy           (busy),
    .owner          (owner),
    .tmr_address    (bus.address),
    .tmr_chipselect (bus.chipselect),
    .tmr_write_n    (bus.write_n),
    .tmr_writedata  (bus.writedata),
    .tmr_irq        (bus.irq)
  );

  // Interval timer: counts period..0, sets TO at 0, reloads if CONT.
  logic        t_to = 1'b0, t_ito = 1'b0, t_cont = 1'b0, t_run = 1'b0;
  logic [31:0] t_per = '0, t_cnt = '0;
  assign bus.irq = t_to & t_ito;

  always @(posedge clk) begin
    if (bus.chipselect && !bus.write_n) begin
      case (bus.address)
        3'd0: t_to <= 1'b0;
        3'd1: begin
          t_ito  <= bus.writedata[0];
          t_cont <= bus.writedata[1];
          if (bus.writedata[3]) t_run <= 1'b0;
          if (bus.writedata[2]) begin
            t_run <= 1'b1;
            t_cnt <= t_per;
          end
        end
        3'd2: t_per[15:0]  <= bus.writedata;
        3'd3: t_per[31:16] <= bus.writedata;
        default: ;
      endcase
    end
    if (t_run) begin
      if (t_cnt == 0) begin
        t_to <= 1'b1;
        if (t_cont) t_cnt <= t_per;
        else t_run <= 1'b0;
      end else begin
        t_cnt <= t_cnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " grant"}, 32'(grant), 0);
    chk({nm, " done"}, 32'(done), 0);
    chk({nm, " busy"}, 32'(busy), 0);
    chk({nm, " owner"}, 32'(owner), 0);
    chk({nm, " cs"}, 32'(bus.chipselect), 0);
    chk({nm, " write_n"}, 32'(bus.write_n), 1);
    chk({nm, " addr"}, 32'(bus.address), 0);
    chk({nm, " data"}, 32'(bus.writedata), 0);
  endtask

  // One full ownership: grant, setup writes, ndone timeouts, release.
  task automatic session(input logic [N-1:0] rq, input logic [N*32-1:0] per,
                         input logic [N-1:0] cnt, input int idx,
                         input int ndone, input bit toggle,
                         input logic [15:0] e_perl, input logic [15:0] e_perh,
                         input logic [15:0] e_ctrl, input int e_eff,
                         input string nm);
    logic [18:0]  got[$];
    logic [18:0]  exp[$];
    logic [N-1:0] oh;
    int           dc, last_c, bad_hold;
    bit           fin;
    oh = '0;
    oh[idx] = 1'b1;
    req_period = per;
    req_continuous = cnt;
    req = rq;
    @(negedge clk);
    chk({nm, " grant"}, 32'(grant), 32'(oh));
    chk({nm, " owner"}, 32'(owner), idx);
    dc = 0; last_c = -1; bad_hold = 0; fin = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      if (bus.chipselect && !bus.write_n)
        got.push_back({bus.address, bus.writedata});
      if (done != '0) begin
        chk({nm, " done"}, 32'(done), 32'(oh));
        if (last_c >= 0) chk({nm, " interval"}, c - last_c, e_eff);
        last_c = c;
        dc++;
        if (dc >= ndone) req = '0;
      end else if (toggle && dc < ndone && busy) begin
        req = N'($urandom) | oh;
      end
      if (!busy) fin = 1'b1;
      else begin
        if (grant !== oh) bad_hold++;
        @(negedge clk);
      end
    end
    chk({nm, " finished"}, 32'(fin), 1);
    chk({nm, " grant held"}, bad_hold, 0);
    chk({nm, " done count"}, dc, ndone);
    exp.push_back({3'd1, 16'h0008});
    exp.push_back({3'd2, e_perl});
    exp.push_back({3'd3, e_perh});
    exp.push_back({3'd0, 16'h0000});
    exp.push_back({3'd1, e_ctrl});
    for (int i = 0; i < ndone; i++) exp.push_back({3'd0, 16'h0000});
    exp.push_back({3'd1, 16'h0008});
    chk({nm, " writes"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s wr%0d", nm, i), 32'(got[i]), 32'(exp[i]));
    req = '0;
  endtask

  // Owner drops req while waiting for a 20-cycle timeout.
  task automatic drop_test(input bit cont);
    logic [18:0] got[$];
    logic [18:0] w0, w1;
    int          dc, first_c;
    bit          fin, quit;
    string       nm;
    nm = cont ? "drop_cont" : "drop_oneshot";
    quit = cont || ABORT;
    req_period = {96'd0, 32'd20};
    req_continuous = {3'b000, cont};
    req = 4'b0001;
    @(negedge clk);
    chk({nm, " grant"}, 32'(grant), 1);
    repeat (7) @(negedge clk);
    chk({nm, " in wait"}, {30'd0, busy, bus.chipselect}, 2);
    req = '0;
    dc = 0; first_c = -1; fin = 1'b0;
    for (int c = 1; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (bus.chipselect && !bus.write_n) begin
        got.push_back({bus.address, bus.writedata});
        if (first_c < 0) first_c = c;
      end
      if (done != '0) dc++;
      if (!busy) fin = 1'b1;
    end
    w0 = (got.size() > 0) ? got[0] : '1;
    w1 = (got.size() > 1) ? got[1] : '1;
    chk({nm, " finished"}, 32'(fin), 1);
    if (quit) begin
      chk({nm, " done count"}, dc, 0);
      chk({nm, " writes"}, got.size(), 1);
      chk({nm, " rel word"}, 32'(w0), 32'({3'd1, 16'h0008}));
      chk({nm, " rel within 2"}, 32'(first_c >= 1 && first_c <= 2), 1);
    end else begin
      chk({nm, " done count"}, dc, 1);
      chk({nm, " writes"}, got.size(), 2);
      chk({nm, " ack word"}, 32'(w0), 32'({3'd0, 16'h0000}));
      chk({nm, " rel word"}, 32'(w1), 32'({3'd1, 16'h0008}));
    end
  endtask

  typedef struct {
    logic [31:0] per;
    logic        cont;
    int          ndone;
    logic [15:0] perl;
    logic [15:0] perh;
    logic [15:0] ctrl;
    int          eff;
  } vec_t;

  initial begin
    vec_t            tbl[6];
    logic [N-1:0]    rq, cn;
    logic [N*32-1:0] pv;
    logic [31:0]     p, ld;
    int              w, eff;
    bit              found;

    tbl[0] = '{32'd100, 1'b0, 1, 16'h0063, 16'h0000, 16'h0005, 100};
    tbl[1] = '{32'd0,   1'b0, 1, 16'h0001, 16'h0000, 16'h0005, 2};
    tbl[2] = '{32'd1,   1'b0, 1, 16'h0001, 16'h0000, 16'h0005, 2};
    tbl[3] = '{32'd2,   1'b1, 2, 16'h0001, 16'h0000, 16'h0007, 2};
    tbl[4] = '{32'd10,  1'b1, 3, 16'h0009, 16'h0000, 16'h0007, 10};
    tbl[5] = '{32'd7,   1'b1, 2, 16'h0006, 16'h0000, 16'h0007, 7};

    reset = 1'b1;
    req = '0;
    req_period = '0;
    req_continuous = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset("por");
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      session(4'b0001, {96'd0, tbl[i].per}, {3'b000, tbl[i].cont}, 0,
              tbl[i].ndone, 1'b0, tbl[i].perl, tbl[i].perh, tbl[i].ctrl,
              tbl[i].eff, $sformatf("tbl%0d", i));

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    session(4'b1010, {4{32'd3}}, 4'b0000, 1, 1, 1'b0,
            16'h0002, 16'h0000, 16'h0005, 3, "rr_first");
    session(4'b1010, {4{32'd3}}, 4'b0000, 3, 1, 1'b0,
            16'h0002, 16'h0000, 16'h0005, 3, "rr_second");

    drop_test(1'b0);
    drop_test(1'b1);
    last_owner = 0;

    for (int s = 0; s < 10; s++) begin
      rq = N'($urandom_range(1, (1 << N) - 1));
      cn = N'($urandom);
      pv = '0;
      for (int i = 0; i < N; i++) pv[32*i +: 32] = $urandom_range(0, 12);
      w = 0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && rq[(last_owner + k) % N]) begin
          w = (last_owner + k) % N;
          found = 1'b1;
        end
      end
      p   = pv[32*w +: 32];
      eff = (p < 2) ? 2 : int'(p);
      ld  = 32'(eff - 1);
      session(rq, pv, cn, w, cn[w] ? int'($urandom_range(1, 3)) : 1, 1'b1,
              ld[15:0], ld[31:16], cn[w] ? 16'h0007 : 16'h0005, eff,
              $sformatf("rand%0d", s));
      last_owner = w;
    end

    req_period = {96'd0, 32'h0003_0005};
    req_continuous = '0;
    req = 4'b0001;
    @(negedge clk);
    chk("rst_mid grant", 32'(grant), 1);
    @(negedge clk);
    chk("rst_mid perl", 32'({bus.address, bus.writedata}),
        32'({3'd2, 16'h0004}));
    @(negedge clk);
    chk("rst_mid perh", 32'({bus.address, bus.writedata}),
        32'({3'd3, 16'h0003}));
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    chk_reset("rst_mid");
    reset = 1'b0;
    session(4'b0001, {96'd0, 32'd4}, 4'b0000, 0, 1, 1'b0,
            16'h0003, 16'h0000, 16'h0005, 4, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_seq_arbiter.md
TIMER_SEQ_ARBITER -- requirements
Module: timer_seq_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 SHALL have parameter IDX_W, default 2, giving the owner index width (must equal clog2(NUM_REQ)).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port req, input, NUM_REQ bits: level request per requester.
REQ-006 SHALL have port req_period, input, NUM_REQ*32 bits: requested period in clk cycles, requester i at [32i+31:32i].
REQ-007 SHALL have port req_continuous, input, NUM_REQ bits: 1 selects a periodic timer, 0 selects one-shot.
REQ-008 SHALL have port grant, output, NUM_REQ bits: one-hot current owner.
REQ-009 SHALL have port done, output, NUM_REQ bits: one-cycle pulse per acknowledged timeout.
REQ-010 SHALL have port busy, output, 1 bit: the FSM is not in IDLE.
REQ-011 SHALL have port owner, output, IDX_W bits: index of the current owner.
REQ-012 SHALL have ports tmr_address (output, 3 bits), tmr_chipselect (output, 1), tmr_write_n (output, 1), tmr_writedata (output, 16): the interval-timer slave write port, no waitrequest, every write completing in one cycle.
REQ-013 SHALL have port tmr_irq, input, 1 bit: the timer interrupt, level, cleared by a status write.

Function
REQ-014 SHALL use timer registers at addr0 status (any write clears TO), addr1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), addr2 period_l and addr3 period_h.
REQ-015 SHALL implement FSM states IDLE, W_STOP, W_PERL, W_PERH, W_STAT, W_CTRL, WAIT, ACK, REL.
REQ-016 SHALL, in IDLE with req != 0, select a winner by round-robin starting after the last owner, assert grant/owner registered, and move to W_STOP on the next cycle.
REQ-017 SHALL sequence one write per cycle: W_STOP addr1=0x0008, W_PERL addr2=load[15:0], W_PERH addr3=load[31:16], W_STAT addr0=0x0000, W_CTRL addr1=0x0005|(cont<<1), then WAIT.
REQ-018 SHALL compute load = req_period-1, sampled at grant; req_period<2 SHALL be clamped to load=1.
REQ-019 SHALL hold tmr_chipselect=1 and tmr_write_n=0 only in W_* states, ACK and REL; otherwise chipselect=0, write_n=1, address=0, writedata=0.
REQ-020 SHALL, in WAIT with tmr_irq=1, go to ACK (addr0 write 0x0000) and pulse done[owner] in that cycle.
REQ-021 SHALL, after ACK, go one-shot to REL and continuous to WAIT, unless req[owner]=0, in which case it goes to REL.
REQ-022 SHALL, in WAIT with continuous and req[owner]=0, go to REL; tmr_irq=1 in the same cycle wins (ACK first, then REL).
REQ-023 SHALL have REL write addr1=0x0008, then clear grant and return to IDLE; the next arbitration SHALL be no earlier than the cycle after IDLE.
REQ-024 SHALL ignore req changes of non-owners during ownership; there is no preemption.

Reset
REQ-025 SHALL, on reset, set state IDLE, grant=0, done=0, busy=0, owner=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, and RR pointer so requester 0 wins first.
REQ-026 SHALL leave the timer itself unaffected by a reset mid-operation; the W_STOP of the next grant resynchronises it.

Configuration
REQ-027 SHALL, with TIMER_SEQ_ABORT_EN defined, treat a one-shot owner dropping req in WAIT as an abort: go to REL with no done pulse.
REQ-028 SHALL, without TIMER_SEQ_ABORT_EN, run a one-shot owner to timeout and ACK regardless of req.

Structure
REQ-029 SHALL place the register address constants, control bit positions, stop/start words and the FSM state enum in package timer_seq_pkg.
REQ-030 SHALL place round-robin selection in sub-module timer_seq_rr_arb (req, last-owner pointer in; one-hot grant and index out).

Verification
REQ-031 SHALL cover: req=0001, period=100, one-shot -> writes 0x0008, 0x0063, 0x0000, 0x0000, 0x0005 on cycles 1-5; irq -> ACK, done[0] pulse, REL 0x0008, busy low.
REQ-032 SHALL cover: req=1010 in IDLE after reset -> grant=0010; then req=1010 again after release -> grant=1000.
REQ-033 SHALL cover: continuous, period=10 -> done[owner] every 10 cycles for 3 timeouts; drop req -> REL within 2 cycles, no further done.
REQ-034 SHALL cover: period=0 and period=1 -> period_l write 0x0001, period_h 0x0000.
REQ-035 SHALL cover: one-shot req drop in WAIT -> with TIMER_SEQ_ABORT_EN, REL with no done; without it, ACK with done on irq.
REQ-036 SHALL cover: reset asserted during W_PERH -> next cycle all outputs at reset values, no write; the next request starts with W_STOP.
